// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// CountdownTimer (top module countdown_timer)
//
// HH:MM:SS countdown timer with its own 1 Hz prescaler. It is loaded with a
// time, counts down to 00:00:00 while running, and then raises an alarm
// that stays up until the start button acknowledges it.
//
// Ports
//   clk       system clock, all logic on the rising edge
//   reset     synchronous, active-high reset
//   load      one-cycle pulse, captures load_hh/load_mm/load_ss (clamped)
//   load_hh   hours, binary, values above 23 clamp to 23
//   load_mm   minutes, binary, values above 59 clamp to 59
//   load_ss   seconds, binary, values above 59 clamp to 59
//   start     start/pause/acknowledge button level; its rising edge acts
//   running   1 while counting
//   done      one-cycle pulse when the count reaches zero
//   alarm     level, 1 while waiting for acknowledge at zero
//   hex0..5   active-low 7-segment digits, [6:0] = g..a;
//             hex5/hex4 = hours tens/units ... hex1/hex0 = seconds tens/units
//
// Parameter CLK_HZ: clk cycles per countdown second.
//
// Optional feature macro ALARM_BLINK_EN: when defined, the display blinks
// (all segments off for half a second, on for half a second) while the
// alarm is up. Without it the display shows a steady 00:00:00 at zero.
// ---------------------------------------------------------------------------
module countdown_timer #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [4:0] load_hh,
   input  logic [5:0] load_mm,
   input  logic [5:0] load_ss,
   input  logic       start,
   output logic       running,
   output logic       done,
   output logic       alarm,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [6:0] hex2,
   output logic [6:0] hex3,
   output logic [6:0] hex4,
   output logic [6:0] hex5
);

   localparam int PRE_WIDTH = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PRE_WIDTH-1:0] PRE_MAX = PRE_WIDTH'(CLK_HZ - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timerState_t;

   timerState_t          state;
   logic [4:0]           hh;
   logic [5:0]           mm;
   logic [5:0]           ss;
   logic [PRE_WIDTH-1:0] preCount;
   logic                 startQ;

   logic                 startEdge;
   logic                 tick;
   logic                 timeZero;
   logic                 lastSecond;
   logic [4:0]           clampHh;
   logic [5:0]           clampMm;
   logic [5:0]           clampSs;
   logic                 blank;

   assign startEdge  = start & ~startQ;
   assign tick       = (state == RUN) && (preCount == PRE_MAX);
   assign timeZero   = (hh == 5'd0) && (mm == 6'd0) && (ss == 6'd0);
   assign lastSecond = (hh == 5'd0) && (mm == 6'd0) && (ss == 6'd1);

   // Out-of-range load values saturate to the largest legal value of each
   // field instead of wrapping, so a sloppy input never shows e.g. 31 hours.
   always_comb begin
      clampHh = load_hh;
      clampMm = load_mm;
      clampSs = load_ss;
      if (load_hh > 5'd23) clampHh = 5'd23;
      if (load_mm > 6'd59) clampMm = 6'd59;
      if (load_ss > 6'd59) clampSs = 6'd59;
   end

   // Main controller: state, time registers, prescaler and registered flags.
   // load overrides everything else (including a simultaneous start edge).
   // In RUN the prescaler advances every cycle and wraps on the tick; in
   // PAUSE it is left alone so the partial second survives the pause. A tick
   // that brings the time to zero overrides a pause edge in the same cycle,
   // because the count has genuinely finished.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         hh       <= 5'd0;
         mm       <= 6'd0;
         ss       <= 6'd0;
         preCount <= '0;
         startQ   <= 1'b0;
         running  <= 1'b0;
         done     <= 1'b0;
         alarm    <= 1'b0;
      end else begin
         startQ <= start;
         done   <= 1'b0;
         if (load) begin
            state    <= IDLE;
            hh       <= clampHh;
            mm       <= clampMm;
            ss       <= clampSs;
            preCount <= '0;
            running  <= 1'b0;
            alarm    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (startEdge && !timeZero) begin
                     state    <= RUN;
                     running  <= 1'b1;
                     preCount <= '0;
                  end
               end
               RUN: begin
                  if (tick) preCount <= '0;
                  else      preCount <= preCount + 1'b1;
                  if (startEdge) begin
                     state   <= PAUSE;
                     running <= 1'b0;
                  end
                  if (tick) begin
                     if (ss != 6'd0) begin
                        ss <= ss - 6'd1;
                     end else if (mm != 6'd0) begin
                        mm <= mm - 6'd1;
                        ss <= 6'd59;
                     end else begin
                        hh <= hh - 5'd1;
                        mm <= 6'd59;
                        ss <= 6'd59;
                     end
                     if (lastSecond) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                        alarm   <= 1'b1;
                     end
                  end
               end
               PAUSE: begin
                  if (startEdge) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
               end
               DONE: begin
                  if (startEdge) begin
                     state <= IDLE;
                     alarm <= 1'b0;
                  end
               end
               default: begin
                  state   <= IDLE;
                  running <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef ALARM_BLINK_EN
   localparam int HALF_HZ     = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
   localparam int BLINK_WIDTH = (HALF_HZ > 2) ? $clog2(HALF_HZ) : 1;
   localparam logic [BLINK_WIDTH-1:0] BLINK_MAX = BLINK_WIDTH'(HALF_HZ - 1);

   logic [BLINK_WIDTH-1:0] blinkCount;
   logic                   blink;

   // Half-second blink generator. It is held cleared outside DONE, so on
   // every entry into DONE the digits are visible for the first half period.
   always_ff @(posedge clk) begin
      if (reset || state != DONE) begin
         blinkCount <= '0;
         blink      <= 1'b0;
      end else if (blinkCount == BLINK_MAX) begin
         blinkCount <= '0;
         blink      <= ~blink;
      end else begin
         blinkCount <= blinkCount + 1'b1;
      end
   end

   assign blank = (state == DONE) && blink;
`else
   assign blank = 1'b0;
`endif

   // Active-low segment pattern for one decimal digit, bit order g..a.
   function automatic logic [6:0] segOf(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   // Display decode straight from the time registers, so the digits change
   // on the same edge as the count with no extra pipeline stage.
   always_comb begin
      hex5 = segOf(4'(hh / 5'd10));
      hex4 = segOf(4'(hh % 5'd10));
      hex3 = segOf(4'(mm / 6'd10));
      hex2 = segOf(4'(mm % 6'd10));
      hex1 = segOf(4'(ss / 6'd10));
      hex0 = segOf(4'(ss % 6'd10));
      if (blank) begin
         hex5 = 7'h7F;
         hex4 = 7'h7F;
         hex3 = 7'h7F;
         hex2 = 7'h7F;
         hex1 = 7'h7F;
         hex0 = 7'h7F;
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// Testbench for countdown_timer with CLK_HZ = 4.
//
// The stimulus process drives directed vectors and, for each one, queues the
// complete expected output picture (running/done/alarm and all six digits)
// tagged with the clock cycle on which it must appear. A separate monitor
// compares the DUT against the queue head on every falling edge.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [4:0] load_hh;
   logic [5:0] load_mm;
   logic [5:0] load_ss;
   logic       start;
   logic       running;
   logic       done;
   logic       alarm;
   logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int          cycle;
      string       name;
      logic        run;
      logic        dn;
      logic        al;
      logic [41:0] hexv;
   } expect_t;

   expect_t expQ[$];

   countdown_timer #(.CLK_HZ(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .load_hh (load_hh),
      .load_mm (load_mm),
      .load_ss (load_ss),
      .start   (start),
      .running (running),
      .done    (done),
      .alarm   (alarm),
      .hex0    (hex0),
      .hex1    (hex1),
      .hex2    (hex2),
      .hex3    (hex3),
      .hex4    (hex4),
      .hex5    (hex5)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Cycle number: after rising edge N the counter reads N.
   always @(posedge clk) cyc <= cyc + 1;

   // Reference 7-segment table, active low, g..a.
   function automatic logic [6:0] segOf(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'h7F;
      endcase
   endfunction

   // Expected hex5..hex0 for a time, or all segments off when blanked.
   function automatic logic [41:0] hexOf(input int h, input int m, input int s, input bit blankIt);
      if (blankIt) return {6{7'h7F}};
      return {segOf(h / 10), segOf(h % 10), segOf(m / 10), segOf(m % 10),
              segOf(s / 10), segOf(s % 10)};
   endfunction

   // Queue an expected output picture for a given cycle.
   task automatic expectAt(input int c, input string nm, input logic r, input logic d,
                           input logic a, input int h, input int m, input int s,
                           input bit blankIt);
      expect_t e;
      e.cycle = c;
      e.name  = nm;
      e.run   = r;
      e.dn    = d;
      e.al    = a;
      e.hexv  = hexOf(h, m, s, blankIt);
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic l, input int h, input int m, input int s,
                                input logic st);
      load    = l;
      load_hh = 5'(h);
      load_mm = 6'(m);
      load_ss = 6'(s);
      start   = st;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Compare the DUT outputs against one expected picture.
   task automatic checkOutput(input expect_t e);
      logic [2:0]  flags;
      logic [41:0] hexAct;
      flags  = {running, done, alarm};
      hexAct = {hex5, hex4, hex3, hex2, hex1, hex0};
      checks++;
      if (flags !== {e.run, e.dn, e.al} || hexAct !== e.hexv) begin
         errors++;
         $display("[TB] FAIL %s cyc=%0d run/done/alarm=%b hex=%h expected run/done/alarm=%b hex=%h",
                  e.name, cyc, flags, hexAct, {e.run, e.dn, e.al}, e.hexv);
      end
   endtask

   // Scoreboard monitor: pops every expectation due on this cycle.
   always @(negedge clk) begin : monitor
      expect_t e;
      while (expQ.size() > 0 && expQ[0].cycle <= cyc) begin
         e = expQ.pop_front();
         if (e.cycle < cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s missed: due cyc=%0d now cyc=%0d", e.name, e.cycle, cyc);
         end else begin
            checkOutput(e);
         end
      end
   end

   // Safety net in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int  e;
      bit  blk;

      // Reset state
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      step(2);
      expectAt(cyc, "reset", 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      step(1);

      // Basic countdown 00:00:03 to zero, done pulse, alarm, optional blink
      applyStimulus(1, 0, 0, 3, 0);
      step(1);
      expectAt(cyc, "load3", 0, 0, 0, 0, 0, 3, 0);
      applyStimulus(0, 0, 0, 0, 1);
      step(1);
      e = cyc;
      expectAt(e, "run3", 1, 0, 0, 0, 0, 3, 0);
      expectAt(e + 4, "tick2", 1, 0, 0, 0, 0, 2, 0);
      expectAt(e + 8, "tick1", 1, 0, 0, 0, 0, 1, 0);
      for (int k = 12; k <= 17; k++) begin
         blk = 1'b0;
`ifdef ALARM_BLINK_EN
         blk = (((k - 12) / 2) % 2) == 1;
`endif
         expectAt(e + k, $sformatf("done%0d", k), 0, (k == 12), 1, 0, 0, 0, blk);
      end
      step(18);

      // Acknowledge the alarm, then a start edge at 00:00:00 is ignored
      start = 1'b0;
      step(1);
      start = 1'b1;
      expectAt(cyc + 1, "ack", 0, 0, 0, 0, 0, 0, 0);
      step(1);
      start = 1'b0;
      step(1);
      start = 1'b1;
      expectAt(cyc + 1, "zeroStartIgnored", 0, 0, 0, 0, 0, 0, 0);
      expectAt(cyc + 6, "zeroStaysIdle", 0, 0, 0, 0, 0, 0, 0);
      step(6);
      start = 1'b0;
      step(1);

      // Borrow chain 01:00:00 -> 00:59:59
      applyStimulus(1, 1, 0, 0, 0);
      step(1);
      applyStimulus(0, 0, 0, 0, 1);
      step(1);
      e = cyc;
      expectAt(e, "borrowRun", 1, 0, 0, 1, 0, 0, 0);
      expectAt(e + 4, "borrow", 1, 0, 0, 0, 59, 59, 0);
      step(4);
      start = 1'b0;
      step(1);

      // Pause keeps the partial second; resume ticks 2 cycles later
      applyStimulus(1, 0, 0, 5, 0);
      step(1);
      applyStimulus(0, 0, 0, 0, 1);
      step(1);
      e = cyc;
      start = 1'b0;
      expectAt(e, "pauseRun", 1, 0, 0, 0, 0, 5, 0);
      expectAt(e + 4, "pauseTick", 1, 0, 0, 0, 0, 4, 0);
      expectAt(e + 6, "paused", 0, 0, 0, 0, 0, 4, 0);
      expectAt(e + 26, "pauseHold", 0, 0, 0, 0, 0, 4, 0);
      step(5);
      start = 1'b1;
      step(21);
      start = 1'b0;
      step(1);
      start = 1'b1;
      expectAt(e + 28, "resume", 1, 0, 0, 0, 0, 4, 0);
      expectAt(e + 29, "resumeWait", 1, 0, 0, 0, 0, 4, 0);
      expectAt(e + 30, "resumeTick", 1, 0, 0, 0, 0, 3, 0);
      step(1);
      start = 1'b0;
      step(2);

      // Clamping and a held start producing a single edge
      applyStimulus(1, 31, 63, 60, 0);
      step(1);
      expectAt(cyc, "clamp", 0, 0, 0, 23, 59, 59, 0);
      applyStimulus(0, 0, 0, 0, 1);
      step(1);
      e = cyc;
      expectAt(e, "heldRun", 1, 0, 0, 23, 59, 59, 0);
      expectAt(e + 4, "heldTick", 1, 0, 0, 23, 59, 58, 0);
      expectAt(e + 50, "held50", 1, 0, 0, 23, 59, 47, 0);
      step(50);

      // load wins over a simultaneous start edge
      start = 1'b0;
      step(1);
      applyStimulus(1, 0, 0, 7, 1);
      step(1);
      expectAt(cyc, "loadWins", 0, 0, 0, 0, 0, 7, 0);
      applyStimulus(0, 0, 0, 0, 1);
      expectAt(cyc + 5, "loadHeldStart", 0, 0, 0, 0, 0, 7, 0);
      step(5);

      // Reset while running
      start = 1'b0;
      step(1);
      start = 1'b1;
      step(1);
      e = cyc;
      start = 1'b0;
      expectAt(e, "rstRun", 1, 0, 0, 0, 0, 7, 0);
      expectAt(e + 4, "rstTick", 1, 0, 0, 0, 0, 6, 0);
      step(5);
      reset = 1'b1;
      expectAt(e + 6, "midRunReset", 0, 0, 0, 0, 0, 0, 0);
      step(1);
      reset = 1'b0;
      expectAt(e + 7, "afterReset", 0, 0, 0, 0, 0, 0, 0);
      expectAt(e + 12, "noPendingTick", 0, 0, 0, 0, 0, 0, 0);
      step(8);

      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL leftover expectations: %0d pending, required 0", expQ.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
